eth_mdio_ctrl: RTL and testbench
================================

Name: eth_mdio_ctrl

Overview:
- IEEE 802.3 clause-22 MDIO management master for the board Ethernet PHY, in the 100 MHz system domain.
- Sequences PHY register reads and writes over eth_mdc/eth_mdio, so the tx datapath can be configured (speed, duplex, loopback) and status polled.
- Top level owns the eth_mdio IOBUF and connects it to mdio_o, mdio_oe and mdio_i.
- Internal requesters use a single-command req/ready handshake.

Parameters:
- MDC_HALF, 20: system clocks per MDC half-period; MDC = 100 MHz / (2*MDC_HALF) = 2.5 MHz. Legal values are 2 and above.
- INIT_PHY, 5'd1: PHY address of the boot write (optional feature only).
- INIT_REG, 5'd0: register address of the boot write (optional feature only).
- INIT_DATA, 16'h2100: data of the boot write, i.e. BMCR 100 Mb/s full duplex with autoneg off (optional feature only).

Ports:
- CLK100MHZ  in  1  system clock; all logic on its rising edge.
- RST  in  1  synchronous reset, active-high.
- req  in  1  command request; accepted when req && ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_phy  in  5  PHY address.
- cmd_reg  in  5  register address.
- cmd_wdata  in  16  write data; ignored for reads.
- ready  out  1  controller idle and able to accept a command.
- done  out  1  one-cycle pulse when a transaction completes.
- rdata  out  16  read data; valid from done, held until the next read's done.
- rd_err  out  1  set with done when the read turnaround bit was not driven low; cleared at the next accept.
- mdc  out  1  to eth_mdc.
- mdio_o  out  1  MDIO output value.
- mdio_oe  out  1  MDIO output enable.
- mdio_i  in  1  MDIO input from the IOBUF.

Behaviour:
- Reset values: ready=1 (0 while the boot write is pending, optional feature), done=0, rdata=0, rd_err=0, mdc=0, mdio_o=1, mdio_oe=0, state=IDLE.
- Frame is 64 bits, index 0..63:
  - 0..31: preamble, all 1s.
  - 32..33: ST = 01.
  - 34..35: OP = 01 write, 10 read.
  - 36..40: PHYAD, MSB first.
  - 41..45: REGAD, MSB first.
  - 46..47: TA.
  - 48..63: data, MSB first.
- States are IDLE, SHIFT, DONE, plus INIT with the optional feature.
- IDLE:
  - ready=1, mdc=0, mdio_oe=0.
  - On req&&ready: latch the command, build the frame, clear rd_err, drive bit 0 with mdio_oe=1, go to SHIFT.
  - ready falls in the same cycle the command is accepted.
- SHIFT:
  - A phase counter runs 0..MDC_HALF-1 and toggles mdc at terminal count.
  - Bit k is driven while mdc is low and held through the following high phase, so the PHY samples it on the rising edge.
  - On each mdc falling edge the bit index increments and the next bit is driven.
- Write transaction: mdio_oe=1 for all 64 bits; TA is driven as 10.
- Read transaction: mdio_oe=0 from bit 46 onward.
  - At the rising edge of bit 47, sample mdio_i; rd_err=1 if it is 1.
  - At the rising edges of bits 48..63, shift mdio_i into rdata, MSB first.
- After the falling edge that ends bit 63, go to DONE. Transaction length is 128*MDC_HALF cycles from accept to DONE (2560 at default).
- DONE lasts one cycle: done=1, mdio_oe=0, mdio_o=1, then IDLE with ready=1. The earliest next accept is the cycle after DONE.
- req while ready=0 is ignored and not queued; command inputs only need to be stable in the accept cycle.
- RST asserted mid-transaction aborts immediately to reset values. No done is issued, and rdata and rd_err are cleared.
- A read with no PHY attached (bus pulled up) completes normally with rd_err=1 and rdata=16'hFFFF.

Optional Feature:
- Macro: ETH_MDIO_INIT_WRITE_EN.
- Defined:
  - After reset the FSM enters INIT, which issues one write of INIT_DATA to INIT_PHY/INIT_REG with exactly the SHIFT timing above, with ready=0.
  - The boot write's DONE pulses done=1; IDLE and ready=1 follow.
  - RST during INIT restarts the boot write.
- Undefined: INIT state and the INIT_* parameters are unused; the FSM leaves reset straight into IDLE with ready=1.

Test Plan:
- Write phy=1, reg=0, wdata=16'h3100 -> sampling mdio_o on 64 mdc rising edges yields 32x1, 01, 01, 00001, 00000, 10, 0011000100000000; mdio_oe=1 throughout; done exactly 2560 cycles after accept; ready=0 until then.
- Read phy=1, reg=2 against a PHY model that drives 0 at TA bit 47 and then 16'h2000 -> mdio_oe=0 from bit 46; rdata=16'h2000, rd_err=0 at done.
- Read with mdio_i held at 1 (no PHY) -> done after 2560 cycles, rd_err=1, rdata=16'hFFFF; the next accepted write clears rd_err.
- req pulsed at bit 20 of an active write -> ignored; only one done seen; the frame is unchanged.
- RST at bit 40 of a read, then req at release -> outputs return to reset values with no done; the new command produces a full 64-bit frame starting from preamble.
- With ETH_MDIO_INIT_WRITE_EN at default parameters -> after RST, ready=0 and frame 32x1, 01, 01, 00001, 00000, 10, 0010000100000000 goes out; done then ready=1; without the macro, ready=1 in the first cycle after reset.

Source files
------------

// File: rtl/eth_mdio_ctrl_if.sv
// Command bus between internal requesters and the MDIO management master.
//   master : requester side   (drives req/cmd_*, sees ready/done/rdata/rd_err)
//   slave  : controller side  (eth_mdio_ctrl)
// req is accepted on a cycle where req && ready; cmd_* only need to be valid then.
interface eth_mdio_ctrl_if;
  logic        req;
  logic        cmd_we;
  logic [4:0]  cmd_phy;
  logic [4:0]  cmd_reg;
  logic [15:0] cmd_wdata;
  logic        ready;
  logic        done;
  logic [15:0] rdata;
  logic        rd_err;

  modport master (
    output req, cmd_we, cmd_phy, cmd_reg, cmd_wdata,
    input  ready, done, rdata, rd_err
  );

  modport slave (
    input  req, cmd_we, cmd_phy, cmd_reg, cmd_wdata,
    output ready, done, rdata, rd_err
  );
endinterface

// File: rtl/eth_mdio_ctrl.sv
// Clause-22 MDIO management master for the board PHY (100 MHz system domain).
// Serialises one 64-bit frame per command (32x preamble, ST, OP, PHYAD, REGAD,
// TA, 16 data bits) on mdc/mdio and returns read data with a one-cycle done.
//
// Ports:
//   CLK100MHZ  system clock, all logic on its rising edge
//   RST        synchronous reset, active high; aborts any transaction
//   bus        command handshake (eth_mdio_ctrl_if.slave)
//   mdc        management clock, 100 MHz / (2*MDC_HALF)
//   mdio_o     MDIO output value    } to the eth_mdio IOBUF
//   mdio_oe    MDIO output enable   }
//   mdio_i     MDIO input           }
//
// Build option ETH_MDIO_INIT_WRITE_EN: after reset the controller issues one
// write of INIT_DATA to INIT_PHY/INIT_REG before becoming ready.
module eth_mdio_ctrl #(
  parameter int unsigned MDC_HALF  = 20,
  parameter logic [4:0]  INIT_PHY  = 5'd1,
  parameter logic [4:0]  INIT_REG  = 5'd0,
  parameter logic [15:0] INIT_DATA = 16'h2100
) (
  input  logic          CLK100MHZ,
  input  logic          RST,
  eth_mdio_ctrl_if.slave bus,
  output logic          mdc,
  output logic          mdio_o,
  output logic          mdio_oe,
  input  logic          mdio_i
);
  localparam int CW = $clog2(MDC_HALF);

`ifdef ETH_MDIO_INIT_WRITE_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_INIT} state_t;
  localparam state_t RST_STATE = S_INIT;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  localparam state_t RST_STATE = S_IDLE;
  // Boot-write parameters have no consumer in this build.
  logic unused_init_cfg;
  assign unused_init_cfg = ^{INIT_PHY, INIT_REG, INIT_DATA};
`endif

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [5:0]    bit_idx;
  logic [63:0]   sh;        // bits still to send, next one at [63]
  logic          we_q, ta_q, rd_err_q;
  logic [15:0]   rsh, rdata_q;
  logic          load, tc, rise, fall, last;
  logic          ld_we;
  logic [4:0]    ld_phy, ld_reg;
  logic [15:0]   ld_wdata;
  logic [63:0]   frame;

  assign tc   = (cnt == CW'(MDC_HALF - 1));
  assign rise = (state == S_SHIFT) && tc && !mdc;
  assign fall = (state == S_SHIFT) && tc &&  mdc;
  assign last = fall && (bit_idx == 6'd63);

  assign bus.ready  = (state == S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.rdata  = rdata_q;
  assign bus.rd_err = rd_err_q;

  always_ff @(posedge CLK100MHZ) begin
    if (RST) state <= RST_STATE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    ld_we    = bus.cmd_we;
    ld_phy   = bus.cmd_phy;
    ld_reg   = bus.cmd_reg;
    ld_wdata = bus.cmd_wdata;
    case (state)
      S_IDLE:  if (bus.req) begin load = 1'b1; state_n = S_SHIFT; end
      S_SHIFT: if (last) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
`ifdef ETH_MDIO_INIT_WRITE_EN
      S_INIT: begin
        load     = 1'b1;
        ld_we    = 1'b1;
        ld_phy   = INIT_PHY;
        ld_reg   = INIT_REG;
        ld_wdata = INIT_DATA;
        state_n  = S_SHIFT;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // Read frames carry 1s where the PHY owns the line; mdio_oe is low there anyway.
  assign frame = {32'hFFFF_FFFF, 2'b01, (ld_we ? 2'b01 : 2'b10), ld_phy, ld_reg,
                  (ld_we ? 2'b10 : 2'b11), (ld_we ? ld_wdata : 16'hFFFF)};

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      cnt      <= '0;
      bit_idx  <= '0;
      sh       <= '1;
      we_q     <= 1'b0;
      ta_q     <= 1'b1;
      rsh      <= '0;
      rdata_q  <= '0;
      rd_err_q <= 1'b0;
      mdc      <= 1'b0;
      mdio_o   <= 1'b1;
      mdio_oe  <= 1'b0;
    end else if (load) begin
      cnt      <= '0;
      bit_idx  <= '0;
      mdc      <= 1'b0;
      we_q     <= ld_we;
      sh       <= {frame[62:0], 1'b1};
      mdio_o   <= frame[63];
      mdio_oe  <= 1'b1;
      rd_err_q <= 1'b0;
    end else if (state == S_SHIFT) begin
      cnt <= tc ? '0 : cnt + CW'(1);
      if (tc) mdc <= ~mdc;
      // PHY-driven bits are captured on the mdc rising edge.
      if (rise && !we_q) begin
        if (bit_idx == 6'd47) ta_q <= mdio_i;
        if (bit_idx >= 6'd48) rsh  <= {rsh[14:0], mdio_i};
      end
      // Next bit goes out on the mdc falling edge.
      if (fall) begin
        if (last) begin
          mdio_o  <= 1'b1;
          mdio_oe <= 1'b0;
          // Publish read results only at completion so rdata stays stable.
          if (!we_q) begin
            rdata_q  <= rsh;
            rd_err_q <= ta_q;
          end
        end else begin
          bit_idx <= bit_idx + 6'd1;
          mdio_o  <= sh[63];
          sh      <= {sh[62:0], 1'b1};
          // Release the line for TA and data on reads.
          if (!we_q && bit_idx == 6'd45) mdio_oe <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_eth_mdio_ctrl.sv
// Self-checking bench for eth_mdio_ctrl: directed and random MDIO transactions
// against a frame/PHY model derived from the frame format rules.
module tb_eth_mdio_ctrl;
  localparam int MDC_HALF = 20;
  localparam int XLEN     = 128 * MDC_HALF;
`ifdef ETH_MDIO_INIT_WRITE_EN
  localparam bit RDY_RST = 1'b0;
`else
  localparam bit RDY_RST = 1'b1;
`endif

  logic CLK100MHZ = 1'b0;
  logic RST, mdc, mdio_o, mdio_oe, mdio_i;
  int   checks = 0, failures = 0;
  logic [15:0] m_rdata = 16'h0;
  logic        m_err   = 1'b0;
  bit          ab;

  eth_mdio_ctrl_if bus();

  eth_mdio_ctrl #(.MDC_HALF(MDC_HALF)) dut (
    .CLK100MHZ(CLK100MHZ), .RST(RST), .bus(bus),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected frame, bit k of the wire at position [63-k].
  function automatic logic [63:0] exp_frame(input bit we, input bit [4:0] phy,
                                            input bit [4:0] rg, input bit [15:0] wd);
    logic [63:0] f;
    bit b;
    for (int k = 0; k < 64; k++) begin
      if (k < 32)       b = 1'b1;
      else if (k == 32) b = 1'b0;
      else if (k == 33) b = 1'b1;
      else if (k == 34) b = !we;
      else if (k == 35) b = we;
      else if (k <= 40) b = phy[40-k];
      else if (k <= 45) b = rg[45-k];
      else if (k == 46) b = 1'b1;
      else if (k == 47) b = 1'b0;
      else              b = wd[63-k];
      f[63-k] = b;
    end
    return f;
  endfunction

  // Value the PHY (or the pull-up) presents during bit k.
  function automatic bit phy_bit(input int k, input bit we, input bit on,
                                 input bit ta, input bit [15:0] rsp);
    if (we || !on || k < 47 || k > 63) return 1'b1;
    if (k == 47) return ta;
    return rsp[63-k];
  endfunction

  task automatic chk_rst(input string tag);
    chk(tag, 64'({bus.ready, bus.done, bus.rdata, bus.rd_err, mdc, mdio_o, mdio_oe}),
        64'({RDY_RST, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0}));
  endtask

  task automatic do_accept(input bit we, input bit [4:0] phy, input bit [4:0] rg,
                           input bit [15:0] wd);
    bus.req = 1'b1; bus.cmd_we = we; bus.cmd_phy = phy; bus.cmd_reg = rg; bus.cmd_wdata = wd;
    chk("ready_before_accept", 64'(bus.ready), 64'(1));
    @(posedge CLK100MHZ); #1;
    bus.req = 1'b0;
    bus.cmd_we = 1'($urandom); bus.cmd_phy = 5'($urandom);
    bus.cmd_reg = 5'($urandom); bus.cmd_wdata = 16'($urandom);
    chk("after_accept", 64'({bus.ready, bus.rd_err, mdio_oe, mdio_o, mdc}), 64'(5'b00110));
  endtask

  task automatic watch(input bit we, input bit [4:0] phy, input bit [4:0] rg,
                       input bit [15:0] wd, input bit on, input bit ta,
                       input bit [15:0] rsp, input int exp_len, input int poke_at,
                       input int abort_at, output bit aborted);
    logic [63:0] fo, foe, ef, eoe;
    logic [16:0] cap;
    int rises, dn, rdy_bad, idle_bad;
    bit prev, poked;
    fo = '1; foe = '0; cap = '0; rises = 0; dn = -1; rdy_bad = 0; idle_bad = 0;
    prev = 1'b0; poked = 1'b0; aborted = 1'b0;
    mdio_i = phy_bit(0, we, on, ta, rsp);
    for (int n = 1; n <= XLEN + 400 && dn < 0 && !aborted; n++) begin
      @(posedge CLK100MHZ); #1;
      if (poked) bus.req = 1'b0;
      if (bus.ready) rdy_bad++;
      if (bus.done) begin dn = n; cap = {bus.rd_err, bus.rdata}; end
      if (mdc && !prev) begin
        if (rises < 64) begin fo[63-rises] = mdio_o; foe[63-rises] = mdio_oe; end
        rises++;
        mdio_i = phy_bit(rises, we, on, ta, rsp);
      end
      prev = mdc;
      if (rises == poke_at && !poked) begin
        poked = 1'b1;
        bus.req = 1'b1; bus.cmd_we = 1'b0; bus.cmd_phy = 5'($urandom);
        bus.cmd_reg = 5'($urandom); bus.cmd_wdata = 16'($urandom);
      end
      if (rises == abort_at) aborted = 1'b1;
    end
    mdio_i = 1'b1;
    if (aborted) return;
    ef  = exp_frame(we, phy, rg, wd);
    eoe = we ? '1 : {{46{1'b1}}, 18'h0};
    if (exp_len > 0) chk("done_latency", 64'(dn), 64'(exp_len));
    else             chk("done_seen", 64'(dn > 0), 64'(1));
    chk("mdc_rises", 64'(rises), 64'(64));
    chk("frame", fo & eoe, ef & eoe);
    chk("mdio_oe", foe, eoe);
    chk("ready_busy", 64'(rdy_bad), 64'(0));
    if (!we) begin
      m_err   = on ? ta : 1'b1;
      m_rdata = on ? rsp : 16'hFFFF;
    end else m_err = 1'b0;
    chk("result", 64'(cap), 64'({m_err, m_rdata}));
    @(posedge CLK100MHZ); #1;
    chk("post_done", 64'({bus.done, bus.ready}), 64'(2'b01));
    for (int n = 0; n < 2 * MDC_HALF + 2; n++) begin
      @(posedge CLK100MHZ); #1;
      if (mdc || mdio_oe || !bus.ready || bus.done) idle_bad++;
    end
    chk("idle_quiet", 64'(idle_bad), 64'(0));
  endtask

  task automatic xact(input bit we, input bit [4:0] phy, input bit [4:0] rg,
                      input bit [15:0] wd, input bit on, input bit ta,
                      input bit [15:0] rsp, input int poke_at);
    bit a;
    do_accept(we, phy, rg, wd);
    watch(we, phy, rg, wd, on, ta, rsp, XLEN, poke_at, -1, a);
  endtask

  initial begin
    RST = 1'b1; mdio_i = 1'b1;
    bus.req = 1'b0; bus.cmd_we = 1'b0; bus.cmd_phy = '0; bus.cmd_reg = '0; bus.cmd_wdata = '0;
    repeat (3) @(posedge CLK100MHZ);
    #1;
    chk_rst("reset_values");
    RST = 1'b0;
`ifdef ETH_MDIO_INIT_WRITE_EN
    watch(1'b1, 5'd1, 5'd0, 16'h2100, 1'b0, 1'b0, 16'h0, -1, -1, -1, ab);
`else
    @(posedge CLK100MHZ); #1;
    chk("ready_after_reset", 64'(bus.ready), 64'(1));
`endif

    // Directed write and reads.
    xact(1'b1, 5'd1, 5'd0, 16'h3100, 1'b0, 1'b0, 16'h0, -1);
    xact(1'b0, 5'd1, 5'd2, 16'h0, 1'b1, 1'b0, 16'h2000, -1);
    xact(1'b0, 5'($urandom), 5'($urandom), 16'h0, 1'b0, 1'b0, 16'h0, -1);
    // Write following an errored read; req pulsed while busy must be dropped.
    xact(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0, 1'b0, 16'h0, 20);

    // Reset mid-read, new command at release.
    do_accept(1'b0, 5'd1, 5'd2, 16'h0);
    watch(1'b0, 5'd1, 5'd2, 16'h0, 1'b1, 1'b0, 16'h1234, XLEN, -1, 41, ab);
    chk("abort_reached", 64'(ab), 64'(1));
    RST = 1'b1;
    @(posedge CLK100MHZ); #1;
    chk_rst("abort_reset_values");
    m_rdata = 16'h0; m_err = 1'b0;
    RST = 1'b0;
`ifdef ETH_MDIO_INIT_WRITE_EN
    watch(1'b1, 5'd1, 5'd0, 16'h2100, 1'b0, 1'b0, 16'h0, -1, -1, -1, ab);
`endif
    xact(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0, 1'b0, 16'h0, -1);

    // Random mix, including PHYs that fail to drive TA low.
    for (int i = 0; i < 4; i++) begin
      bit we, on, ta;
      bit [4:0] p, r;
      bit [15:0] d, rs;
      we = 1'($urandom_range(0, 1));
      on = ($urandom_range(0, 3) != 0);
      ta = ($urandom_range(0, 3) == 0);
      p  = 5'($urandom); r = 5'($urandom);
      d  = 16'($urandom); rs = 16'($urandom);
      xact(we, p, r, d, on, ta, rs, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
